imm_prefix_ctrl: RTL

//   Immediate-operand controller in the decode stage. Converts 5-bit instruction immediates to
//   16-bit operands: sign- or zero-extended, or combined with a preceding IMM prefix instruction

---
 rtl/imm_prefix_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imm_prefix_ctrl.sv
// ============================================================================
// Module   : imm_prefix_ctrl
// Purpose  : Decode-stage immediate controller that extends 5-bit immediates
//            or merges them with a preceding IMM prefix, with prefix tracking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_prefix_ctrl #(
    parameter int DATA_W  = 16,
    parameter int IMM_W   = 5,
    parameter int TIMEOUT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    input  logic                      is_prefix,
    input  logic [DATA_W-IMM_W-1:0]   prefix_data,
    input  logic [IMM_W-1:0]          imm5,
    input  logic                      zero_ext,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      err_clr,
    output logic [DATA_W-1:0]         imm_out,
    output logic                      imm_valid,
    output logic                      prefix_pend,
    output logic                      prefix_err
);

    localparam int PFX_W = DATA_W - IMM_W;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_PREFIXED = 1'b1;

    localparam logic [TMR_W-1:0] c_TMO_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] c_TMR_ONE  = TMR_W'(1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [PFX_W-1:0]  r_prefix;
    logic [TMR_W-1:0]  r_timer;
    logic [DATA_W-1:0] r_imm_out;
    logic              r_imm_valid;
    logic              r_err;

    logic              w_accept;
    logic              w_idle_cycle;
    logic              w_timeout;
    logic              w_err_set;
    logic [DATA_W-1:0] w_ext;

    assign w_accept     = instr_valid & ~stall & ~flush;
    assign w_idle_cycle = ~instr_valid & ~stall & ~flush & (r_state == S_PREFIXED);
    // An accept in the expiry cycle consumes the prefix, so only idle cycles can time out.
    assign w_timeout    = w_idle_cycle & (TIMEOUT != 0) & (r_timer == c_TMO_LAST);
    assign w_err_set    = (w_accept & is_prefix & (r_state == S_PREFIXED)) | w_timeout;
    assign w_ext        = zero_ext ? {{PFX_W{1'b0}}, imm5} : {{PFX_W{imm5[IMM_W-1]}}, imm5};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (!stall) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && is_prefix) w_state_nxt = S_PREFIXED;
                end
                S_PREFIXED: begin
                    if (w_accept && !is_prefix) w_state_nxt = S_IDLE;
                    else if (w_timeout)         w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        prefix_pend = (r_state == S_PREFIXED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imm_out   <= '0;
            r_imm_valid <= 1'b0;
            r_prefix    <= '0;
            r_timer     <= '0;
        end else if (flush) begin
            r_imm_valid <= 1'b0;
            r_prefix    <= '0;
            r_timer     <= '0;
        end else if (!stall) begin
            r_imm_valid <= w_accept & ~is_prefix;
            if (w_accept) begin
                if (is_prefix) begin
                    r_prefix <= prefix_data;
                    r_timer  <= '0;
                end else if (r_state == S_PREFIXED) begin
                    r_imm_out <= {r_prefix, imm5};
                end else begin
                    r_imm_out <= w_ext;
                end
            end else if (r_state == S_PREFIXED) begin
                r_timer <= r_timer + c_TMR_ONE;
                if (w_timeout) r_prefix <= '0;
            end
        end
    end

    // Error events beat a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign imm_out    = r_imm_out;
    assign imm_valid  = r_imm_valid;
    assign prefix_err = r_err;

endmodule

`default_nettype wire
